// File: rtl/tt6502_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tt6502_bus_pkg
// Purpose  : Shared definitions for the byte-wide pin memory bus.
//            Both the initiator (tt6502_bus_master) and the responders
//            import this package.
// Contents : bus_state_t  - initiator FSM states
//            CTRL_*       - bit positions inside bus_ctrl
//            BUS_OE_DRIVE - output-enable value while the initiator drives
// Revision : 1.0 - initial release
// ============================================================================
package tt6502_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ALO  = 3'd1,
    ST_AHI  = 3'd2,
    ST_WR   = 3'd3,
    ST_TURN = 3'd4,
    ST_RD   = 3'd5,
    ST_DONE = 3'd6
  } bus_state_t;

  localparam int CTRL_ALE_LO = 0;
  localparam int CTRL_ALE_HI = 1;
  localparam int CTRL_WE     = 2;
  localparam int CTRL_RD     = 3;

  localparam logic [7:0] BUS_OE_DRIVE = 8'hFF;

endpackage : tt6502_bus_pkg
`default_nettype wire

// File: rtl/tt6502_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tt6502_bus_master
// Purpose  : Initiator of the byte-wide pin memory bus. Accepts one
//            single-byte read/write request at a time and serialises it as
//            address-low, address-high, then data (write) or turnaround +
//            sample (read). All outputs are flops (pure Moore).
// Ports    : clk, rst_n               - clock, synchronous active-low reset
//            req_valid/req_ready      - request handshake (ready only in IDLE)
//            req_we/req_addr/req_wdata- request payload
//            rsp_valid/rsp_rdata      - completion pulse / held read data
//            bus_ctrl                 - ALE_LO, ALE_HI, WE, RD strobes
//            bus_out/bus_oe/bus_in    - bidirectional pin byte split
// Revision : 1.0 - initial release
// ============================================================================
module tt6502_bus_master
  import tt6502_bus_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int RD_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic [3:0]        bus_ctrl,
  output logic [7:0]        bus_out,
  output logic [7:0]        bus_oe,
  input  logic [7:0]        bus_in
);

  bus_state_t        state;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic [3:0]        wait_cnt;
  logic [7:0]        addr_hi;

  // Upper address byte, zero-filled above ADDR_W.
  assign addr_hi = 8'(addr_q >> 8);

  // Outputs are registered alongside the state: every branch assigns the
  // output values belonging to the state being entered, so each output is
  // a pure function of the current state and the latched request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 8'h00;
      wait_cnt  <= 4'd0;
      rsp_rdata <= 8'h00;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      bus_ctrl  <= 4'b0000;
      bus_out   <= 8'h00;
      bus_oe    <= 8'h00;
    end else begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      bus_ctrl  <= 4'b0000;
      bus_out   <= 8'h00;
      bus_oe    <= 8'h00;

      unique case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            we_q                  <= req_we;
            addr_q                <= req_addr;
            wdata_q               <= req_wdata;
            state                 <= ST_ALO;
            bus_out               <= req_addr[7:0];
            bus_ctrl[CTRL_ALE_LO] <= 1'b1;
            bus_oe                <= BUS_OE_DRIVE;
          end else begin
            req_ready <= 1'b1;
          end
        end

        ST_ALO: begin
          state                 <= ST_AHI;
          bus_out               <= addr_hi;
          bus_ctrl[CTRL_ALE_HI] <= 1'b1;
          bus_oe                <= BUS_OE_DRIVE;
        end

        ST_AHI: begin
          if (we_q) begin
            state             <= ST_WR;
            bus_out           <= wdata_q;
            bus_ctrl[CTRL_WE] <= 1'b1;
            bus_oe            <= BUS_OE_DRIVE;
          end else begin
            // Pins released here; RD_WAIT TURN cycles follow before RD.
            state    <= ST_TURN;
            wait_cnt <= 4'(RD_WAIT - 1);
          end
        end

        ST_WR: begin
          state     <= ST_DONE;
          rsp_valid <= 1'b1;
        end

        ST_TURN: begin
          if (wait_cnt == 4'd0) begin
            state             <= ST_RD;
            bus_ctrl[CTRL_RD] <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        ST_RD: begin
          rsp_rdata <= bus_in;
          state     <= ST_DONE;
          rsp_valid <= 1'b1;
        end

        ST_DONE: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end

        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule : tt6502_bus_master
`default_nettype wire

// File: doc/tt6502_bus_master.md
Name: tt6502_bus_master

Overview:
Initiator end of the byte-wide pin memory bus that the tile's 16x8 scratch memory and off-chip memories respond on. Takes single-byte read/write requests from the 6502 core through a valid/ready request port and a one-cycle response pulse. Serialises each request onto the shared 8-bit bidirectional pins as address-low, address-high, then data. Sits between the CPU core and the uio/uo pin wrappers of the top level.

Parameters:
ADDR_W, 16, request address width; must be 9..16; upper unused bits of the address-high byte driven 0.
RD_WAIT, 1, read turnaround/wait cycles between address-high and data sample; legal 1..15.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present; must hold stable until accepted
req_ready  out  1  high only in IDLE; handshake when req_valid & req_ready at posedge
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_W  byte address
req_wdata  in  8  write data
rsp_valid  out  1  one-cycle completion pulse (reads and writes)
rsp_rdata  out  8  read data; valid with rsp_valid on reads, held until next read completes
bus_ctrl  out  4  [0]=ALE_LO, [1]=ALE_HI, [2]=WE, [3]=RD strobes (to uo_out)
bus_out  out  8  pin output byte (to uio_out)
bus_oe  out  8  pin output enables (to uio_oe), all-1 or all-0
bus_in  in  8  pin input byte (from uio_in)

Behaviour:
- States: IDLE, ALO, AHI, WR, TURN, RD, DONE. State register and latched request (we, addr, wdata) are flops. Moore outputs only: no combinational path from req_* or bus_in to any output.
- Reset (rst_n low at posedge): state=IDLE, wait counter=0, rsp_rdata=8'h00. While in IDLE: req_ready=1, rsp_valid=0, bus_ctrl=0, bus_out=0, bus_oe=0.
- IDLE: on handshake latch the request and go to ALO; otherwise stay.
- ALO: bus_out=addr[7:0], bus_ctrl=4'b0001, bus_oe=8'hFF. Next state AHI.
- AHI: bus_out=zero-extended addr[ADDR_W-1:8], bus_ctrl=4'b0010, bus_oe=8'hFF. Next state is WR if we=1, else TURN with the wait counter loaded to RD_WAIT-1.
- WR: bus_out=wdata, bus_ctrl=4'b0100, bus_oe=8'hFF. Next state DONE.
- TURN: bus_oe=0, bus_out=0, bus_ctrl=0. Decrement the counter; go to RD when it is 0.
- RD: bus_oe=0, bus_ctrl=4'b1000. Register bus_in into rsp_rdata at the end of this cycle. Next state DONE.
- DONE: rsp_valid=1, all bus outputs 0. Next state IDLE.
- Latency from the acceptance edge: write rsp_valid occurs 4 cycles later; read rsp_valid occurs 4+RD_WAIT cycles later.
- Minimum request spacing: one IDLE cycle between transactions (DONE→IDLE→accept). There is no pipelining.
- req_valid while not in IDLE is ignored (req_ready=0). Changing the request before acceptance is a protocol violation; it is not checked.
- Writes leave rsp_rdata unchanged.
- Reset mid-transaction aborts immediately: no rsp_valid, bus released (oe=0) the cycle after the reset edge.
- bus_oe is never high in TURN, RD or DONE. This guarantees at least RD_WAIT cycles of turnaround before the responder drives.

Decomposition:
- Package tt6502_bus_pkg holds:
  - the state enum;
  - bus_ctrl bit index constants (CTRL_ALE_LO=0, CTRL_ALE_HI=1, CTRL_WE=2, CTRL_RD=3);
  - BUS_OE_DRIVE=8'hFF.
- The responder side imports the same package.
- No sub-module: the FSM and 4-bit wait counter live in one module.

Test Plan:
- Write: req_we=1, addr=16'h1234, wdata=8'hA5, RD_WAIT=1. Required sequence:
  - cycle 1: bus_out=34, ctrl=0001, oe=FF
  - cycle 2: bus_out=12, ctrl=0010
  - cycle 3: bus_out=A5, ctrl=0100
  - cycle 4: rsp_valid=1
  - rsp_rdata unchanged.
- Read, RD_WAIT=1: addr=16'hBEEF, responder model drives bus_in=8'h5A during RD. Required: ALO EF, AHI BE, one TURN with oe=0, RD ctrl=1000; rsp_valid at cycle 5 with rsp_rdata=5A, held afterwards.
- Read, RD_WAIT=3: same stimulus. Required: three TURN cycles; rsp_valid at cycle 7 with rsp_rdata=5A; oe=0 from TURN onward.
- Busy/back-to-back: req_valid held high across two requests (write 0x0003←0x11, then read 0x0003 against the tile scratch memory model). Required: second handshake only in IDLE after DONE; read returns 0x11; exactly one rsp_valid per request.
- Reset mid-read: assert rst_n=0 during TURN for one cycle. Required:
  - next cycle: IDLE, bus_oe=0, bus_ctrl=0, rsp_rdata=00;
  - no rsp_valid;
  - a fresh request then completes normally.
- ADDR_W=9: read addr=9'h1FF. Required: AHI bus_out=8'h01.
